// File: rtl/mem_port_arbiter.sv
// Arbitrates the byte-wide memory port between store write-back, loads and icache fills,
// serialising each request into per-byte RAM cycles and returning a one-cycle done pulse.
module mem_port_arbiter #(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rb,
  input  logic                    if_valid,
  input  logic [ADDR_W-1:0]       if_addr,
  output logic                    if_done,
  output logic [8*LINE_BYTES-1:0] if_line,
  input  logic                    ld_valid,
  input  logic [ADDR_W-1:0]       ld_addr,
  input  logic [2:0]              ld_len,
  output logic                    ld_done,
  output logic [31:0]             ld_data,
  input  logic                    st_valid,
  input  logic [ADDR_W-1:0]       st_addr,
  input  logic [31:0]             st_data,
  input  logic [2:0]              st_len,
  output logic                    st_done,
  input  logic                    io_buffer_full,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr
);

  localparam int CW = $clog2(LINE_BYTES) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] K_ST = 2'd0;
  localparam logic [1:0] K_LD = 2'd1;
  localparam logic [1:0] K_IF = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [1:0]              kind_q, kind_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [CW-1:0]           len_q, len_d;
  logic [31:0]             sdata_q, sdata_d;
  logic [CW-1:0]           idx_q, idx_d;
  logic                    cv_q, cv_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [7:0]              dout_q, dout_d;
  logic                    wr_q, wr_d;
  logic [8*LINE_BYTES-1:0] buf_q, buf_d;
  logic [31:0]             ld_data_q, ld_data_d;
  logic [8*LINE_BYTES-1:0] line_q, line_d;

  logic [CW-1:0]           idx_inc;
  logic [CW-1:0]           cap_idx;
  logic                    cap_en;
  logic [ADDR_W-1:0]       nxt_addr;
  logic [7:0]              wbyte;
  logic                    is_io;
  logic                    wr_fire;
  logic [8*LINE_BYTES-1:0] buf_cap;

  function automatic logic [CW-1:0] to_len(input logic [2:0] l);
    to_len = (l == 3'd0) ? CW'(1) : CW'(l);
  endfunction

  assign idx_inc  = idx_q + CW'(1);
  assign cap_idx  = idx_q - CW'(1);
  assign nxt_addr = base_q + ADDR_W'(idx_inc);
  assign wbyte    = 8'(sdata_q >> {idx_inc, 3'b000});
  assign is_io    = (addr_q[17:16] == 2'b11);
  assign wr_fire  = wr_q && !(is_io && io_buffer_full);

  // mem_din always carries the byte addressed one cycle earlier, i.e. byte idx_q-1.
  assign cap_en = (state_q == S_RD) && cv_q;

  genvar gi;
  for (gi = 0; gi < LINE_BYTES; gi++) begin : g_cap
    assign buf_cap[8*gi +: 8] = (cap_en && cap_idx == CW'(gi)) ? mem_din : buf_q[8*gi +: 8];
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    base_d    = base_q;
    len_d     = len_q;
    sdata_d   = sdata_q;
    idx_d     = idx_q;
    cv_d      = cv_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    wr_d      = wr_q;
    buf_d     = buf_q;
    ld_data_d = ld_data_q;
    line_d    = line_q;

    case (state_q)
      S_IDLE: begin
        if (st_valid) begin
          state_d = S_WR;
          kind_d  = K_ST;
          base_d  = st_addr;
          len_d   = to_len(st_len);
          sdata_d = st_data;
          idx_d   = '0;
          addr_d  = st_addr;
          dout_d  = st_data[7:0];
          wr_d    = 1'b1;
        end else if (ld_valid && !rb) begin
          state_d = S_RD;
          kind_d  = K_LD;
          base_d  = ld_addr;
          len_d   = to_len(ld_len);
          idx_d   = '0;
          cv_d    = 1'b0;
          addr_d  = ld_addr;
          buf_d   = '0;
        end else if (if_valid && !rb) begin
          state_d = S_RD;
          kind_d  = K_IF;
          base_d  = if_addr;
          len_d   = CW'(LINE_BYTES);
          idx_d   = '0;
          cv_d    = 1'b0;
          addr_d  = if_addr;
          buf_d   = '0;
        end
      end
      S_RD: begin
        if (rb) begin
          state_d = S_IDLE;
          idx_d   = '0;
          cv_d    = 1'b0;
          addr_d  = '0;
        end else if (cv_q && idx_q == len_q) begin
          state_d = S_DONE;
          buf_d   = buf_cap;
          idx_d   = '0;
          cv_d    = 1'b0;
          addr_d  = '0;
          if (kind_q == K_LD) ld_data_d = buf_cap[31:0];
          else                line_d    = buf_cap;
        end else begin
          buf_d  = buf_cap;
          idx_d  = idx_inc;
          cv_d   = 1'b1;
          addr_d = (idx_inc < len_q) ? nxt_addr : '0;
        end
      end
      S_WR: begin
        if (wr_fire) begin
          if (idx_q == len_q - CW'(1)) begin
            state_d = S_DONE;
            idx_d   = '0;
            addr_d  = '0;
            dout_d  = '0;
            wr_d    = 1'b0;
          end else begin
            idx_d  = idx_inc;
            addr_d = nxt_addr;
            dout_d = wbyte;
            // An IO byte is followed by one idle cycle before the next is issued.
            wr_d   = !is_io;
          end
        end else if (!wr_q) begin
          wr_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      kind_q    <= K_ST;
      base_q    <= '0;
      len_q     <= '0;
      sdata_q   <= '0;
      idx_q     <= '0;
      cv_q      <= 1'b0;
      addr_q    <= '0;
      dout_q    <= '0;
      wr_q      <= 1'b0;
      buf_q     <= '0;
      ld_data_q <= '0;
      line_q    <= '0;
    end else if (rdy) begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      base_q    <= base_d;
      len_q     <= len_d;
      sdata_q   <= sdata_d;
      idx_q     <= idx_d;
      cv_q      <= cv_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      wr_q      <= wr_d;
      buf_q     <= buf_d;
      ld_data_q <= ld_data_d;
      line_q    <= line_d;
    end
  end

  // A rollback arriving in the DONE cycle cancels a speculative read's pulse.
  assign st_done  = (state_q == S_DONE) && (kind_q == K_ST);
  assign ld_done  = (state_q == S_DONE) && (kind_q == K_LD) && !rb;
  assign if_done  = (state_q == S_DONE) && (kind_q == K_IF) && !rb;
  assign ld_data  = ld_data_q;
  assign if_line  = line_q;
  assign mem_a    = 32'(addr_q);
  assign mem_dout = dout_q;
  assign mem_wr   = wr_q && rdy && !(is_io && io_buffer_full);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expectations, a negedge
// monitor pops and compares bus cycles and done pulses as the DUT produces them.
module tb_mem_port_arbiter;

  localparam int LB = 16;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst, rdy, rb;
  logic          if_valid, ld_valid, st_valid;
  logic [AW-1:0] if_addr, ld_addr, st_addr;
  logic [2:0]    ld_len, st_len;
  logic [31:0]   st_data;
  logic          io_buffer_full;
  logic [7:0]    mem_din = 8'h00;
  logic          if_done, ld_done, st_done, mem_wr;
  logic [8*LB-1:0] if_line;
  logic [31:0]   ld_data, mem_a;
  logic [7:0]    mem_dout;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LINE_BYTES(LB), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rb(rb),
    .if_valid(if_valid), .if_addr(if_addr), .if_done(if_done), .if_line(if_line),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_len(ld_len), .ld_done(ld_done), .ld_data(ld_data),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_len(st_len), .st_done(st_done),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: registered read, frozen together with the rest of the system while rdy is low.
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    case (a)
      32'h100: return 8'h11;
      32'h101: return 8'h22;
      32'h102: return 8'h33;
      32'h103: return 8'h44;
      default: return a[7:0] + 8'h3C;
    endcase
  endfunction

  always @(posedge clk) if (rdy) mem_din <= ram_rd(mem_a);

  typedef struct { int cyc; logic [31:0] a; } ra_t;
  typedef struct { int cyc; logic [31:0] a; logic [7:0] d; } wr_t;
  typedef struct { int cyc; logic [8*LB-1:0] d; } dn_t;

  ra_t ra_q[$];
  wr_t wr_q[$];
  dn_t ld_q[$];
  dn_t if_q[$];
  int  st_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d: got %0h required %0h", name, cyc, act, exp);
  endtask

  task automatic fail_evt(input string name);
    n_chk++;
    $display("FAIL %s cyc=%0d: event seen, none required", name, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      ra_t r; wr_t w; dn_t d; int s;
      if (ra_q.size() > 0 && ra_q[0].cyc == cyc) begin
        r = ra_q.pop_front();
        chk("rd_addr{wr,a}", 128'({mem_wr, mem_a}), 128'({1'b0, r.a}));
      end
      if (mem_wr) begin
        if (wr_q.size() == 0) fail_evt("unexpected_write");
        else begin
          w = wr_q.pop_front();
          $display("write cyc=%0d a=%h d=%h", cyc, mem_a, mem_dout);
          chk("wr_cycle", 128'(cyc), 128'(w.cyc));
          chk("wr_addr", 128'(mem_a), 128'(w.a));
          chk("wr_data", 128'(mem_dout), 128'(w.d));
        end
      end
      if (ld_done) begin
        if (ld_q.size() == 0) fail_evt("unexpected_ld_done");
        else begin
          d = ld_q.pop_front();
          $display("ld_done cyc=%0d data=%h", cyc, ld_data);
          chk("ld_cycle", 128'(cyc), 128'(d.cyc));
          chk("ld_data", 128'(ld_data), d.d);
        end
      end
      if (if_done) begin
        if (if_q.size() == 0) fail_evt("unexpected_if_done");
        else begin
          d = if_q.pop_front();
          $display("if_done cyc=%0d line=%h", cyc, if_line);
          chk("if_cycle", 128'(cyc), 128'(d.cyc));
          chk("if_line", if_line, d.d);
        end
      end
      if (st_done) begin
        if (st_q.size() == 0) fail_evt("unexpected_st_done");
        else begin
          s = st_q.pop_front();
          $display("st_done cyc=%0d", cyc);
          chk("st_cycle", 128'(cyc), 128'(s));
        end
      end
    end
  end

  task automatic do_ld(input logic [31:0] a, input logic [2:0] n);
    int k = 0;
    ld_addr = a; ld_len = n; ld_valid = 1'b1;
    do begin @(negedge clk); k++; end while (!ld_done && k < 300);
    if (!ld_done) fail_evt("ld_timeout");
    ld_valid = 1'b0;
  endtask

  task automatic do_if(input logic [31:0] a);
    int k = 0;
    if_addr = a; if_valid = 1'b1;
    do begin @(negedge clk); k++; end while (!if_done && k < 300);
    if (!if_done) fail_evt("if_timeout");
    if_valid = 1'b0;
  endtask

  task automatic do_st(input logic [31:0] a, input logic [31:0] dat, input logic [2:0] n);
    int k = 0;
    st_addr = a; st_data = dat; st_len = n; st_valid = 1'b1;
    do begin @(negedge clk); k++; end while (!st_done && k < 300);
    if (!st_done) fail_evt("st_timeout");
    st_valid = 1'b0;
  endtask

  task automatic next_test(output int t0);
    repeat (2) @(posedge clk);
    #1;
    t0 = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d: simulation did not finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [8*LB-1:0] line;
    rst = 1'b1; rdy = 1'b1; rb = 1'b0;
    if_valid = 1'b0; ld_valid = 1'b0; st_valid = 1'b0;
    if_addr = '0; ld_addr = '0; st_addr = '0; ld_len = '0; st_len = '0; st_data = '0;
    io_buffer_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ctl", 128'({ld_done, if_done, st_done, mem_wr, mem_a, mem_dout, ld_data}), 128'(0));
    chk("reset_if_line", if_line, 128'(0));

    // 4-byte load, bytes 11 22 33 44
    next_test(t0);
    for (int k = 0; k < 4; k++) ra_q.push_back('{t0 + 1 + k, 32'h100 + k});
    ra_q.push_back('{t0 + 7, 32'h0});
    ld_q.push_back('{t0 + 6, 128'h44332211});
    do_ld(32'h100, 3'd4);

    // store, load and fill requested together; fixed priority st > ld > if
    next_test(t0);
    wr_q.push_back('{t0 + 1, 32'h200, 8'hCD});
    wr_q.push_back('{t0 + 2, 32'h201, 8'hAB});
    st_q.push_back(t0 + 3);
    ra_q.push_back('{t0 + 5, 32'h100});
    ra_q.push_back('{t0 + 6, 32'h101});
    ld_q.push_back('{t0 + 8, 128'h2211});
    for (int k = 0; k < 16; k++) ra_q.push_back('{t0 + 10 + k, 32'h1000 + k});
    for (int k = 0; k < 16; k++) line[8*k +: 8] = 8'h3C + 8'(k);
    if_q.push_back('{t0 + 27, line});
    fork
      do_st(32'h200, 32'hABCD, 3'd2);
      do_ld(32'h100, 3'd2);
      do_if(32'h1000);
    join

    // fill aborted by rollback in cycle 5; pending store granted in cycle 6
    next_test(t0);
    for (int k = 0; k < 5; k++) ra_q.push_back('{t0 + 1 + k, 32'h2000 + k});
    ra_q.push_back('{t0 + 6, 32'h0});
    wr_q.push_back('{t0 + 7, 32'h300, 8'h5A});
    st_q.push_back(t0 + 8);
    fork
      begin
        if_addr = 32'h2000; if_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1 rb = 1'b1; if_valid = 1'b0;
        @(posedge clk);
        #1 rb = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 do_st(32'h300, 32'h5A, 3'd1);
      end
    join

    // IO store held off by a full UART buffer
    next_test(t0);
    for (int k = 0; k < 3; k++) ra_q.push_back('{t0 + 1 + k, 32'h30000});
    wr_q.push_back('{t0 + 4, 32'h30000, 8'h77});
    st_q.push_back(t0 + 5);
    io_buffer_full = 1'b1;
    fork
      begin repeat (4) @(posedge clk); #1 io_buffer_full = 1'b0; end
      do_st(32'h30000, 32'h77, 3'd1);
    join

    // two IO bytes need an idle cycle between them
    next_test(t0);
    wr_q.push_back('{t0 + 1, 32'h30000, 8'h02});
    wr_q.push_back('{t0 + 3, 32'h30001, 8'h01});
    st_q.push_back(t0 + 4);
    do_st(32'h30000, 32'h0102, 3'd2);

    // rdy low in cycle 3 of a 4-byte load
    next_test(t0);
    ra_q.push_back('{t0 + 1, 32'h100});
    ra_q.push_back('{t0 + 2, 32'h101});
    ra_q.push_back('{t0 + 3, 32'h102});
    ra_q.push_back('{t0 + 4, 32'h102});
    ra_q.push_back('{t0 + 5, 32'h103});
    ld_q.push_back('{t0 + 7, 128'h44332211});
    fork
      begin repeat (3) @(posedge clk); #1 rdy = 1'b0; @(posedge clk); #1 rdy = 1'b1; end
      do_ld(32'h100, 3'd4);
    join

    // rdy low during the only write cycle
    next_test(t0);
    ra_q.push_back('{t0 + 1, 32'h400});
    wr_q.push_back('{t0 + 2, 32'h400, 8'h9C});
    st_q.push_back(t0 + 3);
    fork
      begin @(posedge clk); #1 rdy = 1'b0; @(posedge clk); #1 rdy = 1'b1; end
      do_st(32'h400, 32'h9C, 3'd1);
    join

    // address wrap at the top of the space, upper bytes zero
    next_test(t0);
    ra_q.push_back('{t0 + 1, 32'hFFFF_FFFF});
    ra_q.push_back('{t0 + 2, 32'h0});
    ld_q.push_back('{t0 + 4, 128'h3C3B});
    do_ld(32'hFFFF_FFFF, 3'd2);

    // load held off in IDLE while rb is high
    next_test(t0);
    ra_q.push_back('{t0 + 2, 32'h100});
    ld_q.push_back('{t0 + 4, 128'h11});
    fork
      begin rb = 1'b1; @(posedge clk); #1 rb = 1'b0; end
      do_ld(32'h100, 3'd1);
    join

    begin
      int k = 0;
      while ((ra_q.size() + wr_q.size() + ld_q.size() + if_q.size() + st_q.size()) != 0 && k < 100) begin
        @(posedge clk);
        k++;
      end
    end
    chk("queues_drained", 128'(ra_q.size() + wr_q.size() + ld_q.size() + if_q.size() + st_q.size()), 128'(0));
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
